// File: rtl/smc_mac_lite17.sv
// smc_mac_lite17 -- static memory access controller.
// Splits each AHB access into one or more external cycles on a narrower
// static memory bus. Every external cycle runs SETUP / STROBE / HOLD with
// parameterised wait states. Read bytes are assembled into rd_buf.
module smc_mac_lite17 #(
    parameter int MEM_BW    = 1,  // log2 of external bus width in bytes
    parameter int WS_SETUP  = 1,
    parameter int WS_STROBE = 2,
    parameter int WS_HOLD   = 1
) (
    input  logic        hclk17,
    input  logic        n_sys_reset17,
    input  logic        new_access17,
    input  logic [31:0] addr,
    input  logic [1:0]  xfer_size17,
    input  logic        n_read17,
    input  logic [31:0] write_data17,
    input  logic [31:0] ext_data_in,
    output logic        smc_idle17,
    output logic        smc_done17,
    output logic        mac_done17,
    output logic [31:0] read_data17,
    output logic [31:0] ext_addr,
    output logic        ext_cs_n,
    output logic        ext_oe_n,
    output logic        ext_we_n,
    output logic [3:0]  ext_be_n,
    output logic [31:0] ext_data_out,
    output logic        ext_data_oe
);

    localparam int MEMBYTES = 1 << MEM_BW;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state, nxt_state;
    logic [3:0]  cnt, nxt_cnt;
    logic [1:0]  k, nxt_k;
    logic [1:0]  size, nxt_size;
    logic [31:0] base, nxt_base;
    logic        wr, nxt_wr;
    logic [31:0] rd_buf;

    logic        last_cyc;
    logic        final_acc;
    logic        capture;
    logic        rd_load;
    logic        nxt_active;
    logic [31:0] nxt_addr;
    logic [1:0]  nxt_off;
    logic [1:0]  lane_pos;
    logic [2:0]  span_lo;
    logic [2:0]  span_hi;
    logic [31:0] nxt_dout;
    logic [3:0]  nxt_be_n;

    // Index of the final external access for a given transfer size.
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        int sh;
        sh = int'(sz) - MEM_BW;
        return (sh <= 0) ? 2'd0 : 2'((1 << sh) - 1);
    endfunction

    assign smc_idle17  = (state == IDLE);
    assign smc_done17  = (state == HOLD) && last_cyc;
    assign mac_done17  = (state != IDLE) && final_acc;
    assign read_data17 = rd_buf;

    // Sequencing decode: next state, wait counter, access index and capture.
    always_comb begin
        last_cyc  = (cnt == 4'd0);
        final_acc = (k == last_idx(size));
        capture   = new_access17 && ((state == IDLE) || (smc_done17 && final_acc));
        rd_load   = (state == STROBE) && last_cyc && !wr;
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_k     = k;
        nxt_base  = base;
        nxt_size  = size;
        nxt_wr    = wr;
        case (state)
            IDLE: ;
            SETUP: begin
                if (last_cyc) begin
                    nxt_state = STROBE;
                    nxt_cnt   = 4'(WS_STROBE - 1);
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (last_cyc) begin
                    nxt_state = HOLD;
                    nxt_cnt   = 4'(WS_HOLD - 1);
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (!last_cyc) begin
                    nxt_cnt = cnt - 4'd1;
                end else if (!final_acc) begin
                    nxt_state = SETUP;
                    nxt_cnt   = 4'(WS_SETUP - 1);
                    nxt_k     = k + 2'd1;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        // A new transfer wins over IDLE when it arrives on the final HOLD cycle.
        if (capture) begin
            nxt_state = SETUP;
            nxt_cnt   = 4'(WS_SETUP - 1);
            nxt_k     = 2'd0;
            nxt_base  = addr;
            nxt_size  = xfer_size17;
            nxt_wr    = n_read17;
        end
    end

    // External bus decode for the upcoming cycle: address, lane steering, byte enables.
    always_comb begin
        nxt_active = (nxt_state != IDLE);
        nxt_addr   = (nxt_base & ~(32'(MEMBYTES) - 32'd1)) + (32'(nxt_k) << MEM_BW);
        nxt_off    = nxt_addr[1:0];
        span_lo    = {1'b0, nxt_base[1:0]};
        span_hi    = span_lo + (3'd1 << nxt_size);
        nxt_dout   = '0;
        nxt_be_n   = 4'hF;
        lane_pos   = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (j < MEMBYTES) begin
                lane_pos = nxt_off + 2'(j);
                nxt_dout[8*j +: 8] = write_data17[{lane_pos, 3'b000} +: 8];
                // Sub-width transfers enable only the bytes they cover.
                if (int'(nxt_size) >= MEM_BW)
                    nxt_be_n[j] = 1'b0;
                else
                    nxt_be_n[j] = !(({1'b0, lane_pos} >= span_lo) && ({1'b0, lane_pos} < span_hi));
            end
        end
    end

    // Controller state, read assembly and registered external strobes.
    always_ff @(posedge hclk17 or negedge n_sys_reset17) begin
        if (!n_sys_reset17) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            k            <= 2'd0;
            base         <= '0;
            size         <= 2'd0;
            wr           <= 1'b0;
            rd_buf       <= '0;
            ext_addr     <= '0;
            ext_cs_n     <= 1'b1;
            ext_oe_n     <= 1'b1;
            ext_we_n     <= 1'b1;
            ext_be_n     <= 4'hF;
            ext_data_out <= '0;
            ext_data_oe  <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            k     <= nxt_k;
            base  <= nxt_base;
            size  <= nxt_size;
            wr    <= nxt_wr;
            if (capture) begin
                rd_buf <= '0;
            end else if (rd_load) begin
                // Lanes land at their byte position within the AHB word.
                for (int j = 0; j < 4; j++) begin
                    if (j < MEMBYTES)
                        rd_buf[{2'(ext_addr[1:0] + 2'(j)), 3'b000} +: 8] <= ext_data_in[8*j +: 8];
                end
            end
            if (nxt_active)
                ext_addr <= nxt_addr;
            ext_cs_n     <= !nxt_active;
            ext_oe_n     <= !((nxt_state == STROBE) && !nxt_wr);
            ext_we_n     <= !((nxt_state == STROBE) && nxt_wr);
            ext_be_n     <= nxt_active ? nxt_be_n : 4'hF;
            ext_data_out <= (nxt_active && nxt_wr) ? nxt_dout : '0;
            ext_data_oe  <= nxt_active && nxt_wr;
        end
    end

endmodule

// File: tb/tb_smc_mac_lite17.sv
// Bench for smc_mac_lite17: three configurations (16-bit 1/2/1, 8-bit 1/2/1,
// 32-bit 3/1/2) driven by directed table vectors, hand sequences and random
// transfers, all checked cycle by cycle against a byte-level bus model.
module tb_smc_mac_lite17;

    logic hclk17 = 1'b0;
    logic n_sys_reset17 = 1'b0;
    always #5 hclk17 = ~hclk17;

    logic [2:0]        na;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        xsz;
    logic              nrd;
    logic [7:0]        mem [0:4095];

    logic [2:0]        idle_o, done_o, mac_o, cs_o, oe_o, we_o, doe_o;
    logic [2:0][31:0]  rd_o, ea_o, do_o, ein;
    logic [2:0][3:0]   be_o;

    int ntests = 0;
    int nfail  = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            smc_mac_lite17 #(
                .MEM_BW   (g == 0 ? 1 : (g == 1 ? 0 : 2)),
                .WS_SETUP (g == 2 ? 3 : 1),
                .WS_STROBE(g == 2 ? 1 : 2),
                .WS_HOLD  (g == 2 ? 2 : 1)
            ) u_dut (
                .hclk17       (hclk17),
                .n_sys_reset17(n_sys_reset17),
                .new_access17 (na[g]),
                .addr         (addr),
                .xfer_size17  (xsz),
                .n_read17     (nrd),
                .write_data17 (wdata),
                .ext_data_in  (ein[g]),
                .smc_idle17   (idle_o[g]),
                .smc_done17   (done_o[g]),
                .mac_done17   (mac_o[g]),
                .read_data17  (rd_o[g]),
                .ext_addr     (ea_o[g]),
                .ext_cs_n     (cs_o[g]),
                .ext_oe_n     (oe_o[g]),
                .ext_we_n     (we_o[g]),
                .ext_be_n     (be_o[g]),
                .ext_data_out (do_o[g]),
                .ext_data_oe  (doe_o[g])
            );
            // Byte-addressed memory model behind each external bus.
            assign ein[g] = {mem[ea_o[g][11:0] + 12'd3], mem[ea_o[g][11:0] + 12'd2],
                             mem[ea_o[g][11:0] + 12'd1], mem[ea_o[g][11:0]]};
        end
    endgenerate

    function automatic int p_bw(input int i); return (i == 0) ? 1 : ((i == 1) ? 0 : 2); endfunction
    function automatic int p_s (input int i); return (i == 2) ? 3 : 1; endfunction
    function automatic int p_st(input int i); return (i == 2) ? 1 : 2; endfunction
    function automatic int p_h (input int i); return (i == 2) ? 2 : 1; endfunction

    task automatic chk(input string nm, input int i, input int c, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s inst%0d cyc%0d got=%h want=%h", nm, i, c, act, exp);
        end
    endtask

    task automatic chk_reset(input int i);
        chk("rst_idle", i, 0, 32'(idle_o[i]), 32'd1);
        chk("rst_done", i, 0, 32'(done_o[i]), 32'd0);
        chk("rst_mac",  i, 0, 32'(mac_o[i]),  32'd0);
        chk("rst_rd",   i, 0, rd_o[i],        32'd0);
        chk("rst_addr", i, 0, ea_o[i],        32'd0);
        chk("rst_cs",   i, 0, 32'(cs_o[i]),   32'd1);
        chk("rst_oe",   i, 0, 32'(oe_o[i]),   32'd1);
        chk("rst_we",   i, 0, 32'(we_o[i]),   32'd1);
        chk("rst_be",   i, 0, 32'(be_o[i]),   32'hF);
        chk("rst_dout", i, 0, do_o[i],        32'd0);
        chk("rst_doe",  i, 0, 32'(doe_o[i]),  32'd0);
    endtask

    // Runs one transfer from its request cycle (time just after a rising edge)
    // and checks every bus cycle; returns at the falling edge of the last cycle.
    task automatic xfer(input int i, input logic [31:0] a, input logic [1:0] sz, input logic w,
                        input logic [31:0] wd, input bit chained,
                        output logic [31:0] ea0, output logic [3:0] be0,
                        output logic [31:0] rdf, output int cyc);
        int bw, mb, n, s, st, h, t, ci;
        logic [31:0] al, e, b, exp_do, rdm;
        logic [3:0]  exp_be;
        bit strobe;
        bw = p_bw(i); mb = 1 << bw;
        n  = (int'(sz) <= bw) ? 1 : (1 << (int'(sz) - bw));
        s = p_s(i); st = p_st(i); h = p_h(i); t = s + st + h;
        al  = a & ~(32'(mb) - 32'd1);
        rdm = '0;
        addr = a; xsz = sz; nrd = w; wdata = wd; na[i] = 1'b1;
        if (!chained) begin
            @(negedge hclk17);
            chk("idle_pre", i, 0, 32'(idle_o[i]), 32'd1);
        end
        @(posedge hclk17); #1;
        na[i] = 1'b0;
        cyc = 0; ci = 0; ea0 = '0; be0 = 4'hF; rdf = '0;
        for (int k = 0; k < n; k++) begin
            e = al + 32'(k * mb);
            exp_be = 4'hF; exp_do = '0;
            for (int j = 0; j < mb; j++) begin
                b = e + 32'(j);
                if (b >= a && b < a + (32'd1 << sz)) exp_be[j] = 1'b0;
                exp_do[8*j +: 8] = wd[8*int'(b[1:0]) +: 8];
            end
            for (int c = 0; c < t; c++) begin
                ci++;
                strobe = (c >= s) && (c < s + st);
                @(negedge hclk17);
                chk("idle", i, ci, 32'(idle_o[i]), 32'd0);
                chk("cs_n", i, ci, 32'(cs_o[i]),   32'd0);
                chk("oe_n", i, ci, 32'(oe_o[i]),   32'(!(strobe && !w)));
                chk("we_n", i, ci, 32'(we_o[i]),   32'(!(strobe && w)));
                chk("d_oe", i, ci, 32'(doe_o[i]),  32'(w));
                chk("addr", i, ci, ea_o[i],        e);
                chk("be_n", i, ci, 32'(be_o[i]),   32'(exp_be));
                chk("done", i, ci, 32'(done_o[i]), 32'(c == t - 1));
                chk("mac",  i, ci, 32'(mac_o[i]),  32'(k == n - 1));
                chk("rdat", i, ci, rd_o[i],        rdm);
                if (w && c >= s) chk("dout", i, ci, do_o[i], exp_do);
                if (ci == 1) begin ea0 = ea_o[i]; be0 = be_o[i]; end
                if (done_o[i] && mac_o[i] && cyc == 0) cyc = ci;
                rdf = rd_o[i];
                // Memory bytes reach the AHB word at the end of the strobe.
                if (!w && c == s + st - 1)
                    for (int j = 0; j < mb; j++) begin
                        b = e + 32'(j);
                        rdm[8*int'(b[1:0]) +: 8] = mem[b[11:0]];
                    end
                if (!(k == n - 1 && c == t - 1)) begin
                    @(posedge hclk17); #1;
                end
            end
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;
        logic [31:0] wd;
        logic [31:0] ea0;
        logic [3:0]  be0;
        logic [31:0] rd;
        int          cyc;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic [31:0] ea0, rdf, a, wd;
        logic [3:0]  be0;
        logic [1:0]  sz;
        logic        w;
        int cyc, i, prev;
        bit chain;

        for (int x = 0; x < 4096; x++) mem[x] = 8'(x) ^ 8'hA5;
        mem[12'h100] = 8'hAA; mem[12'h101] = 8'hAA;
        mem[12'h102] = 8'hBB; mem[12'h103] = 8'hBB;

        vt[0] = '{0, 32'h100, 2'd2, 1'b0, 32'h0,        32'h100, 4'hC, 32'hBBBBAAAA, 8};
        vt[1] = '{0, 32'h203, 2'd0, 1'b1, 32'h5A000000, 32'h202, 4'hD, 32'h0,        4};
        vt[2] = '{1, 32'h40,  2'd2, 1'b1, 32'h44332211, 32'h40,  4'hE, 32'h0,        16};
        vt[3] = '{2, 32'h06,  2'd1, 1'b0, 32'h0,        32'h04,  4'h3, 32'hA2A3A0A1, 6};
        vt[4] = '{1, 32'h41,  2'd0, 1'b0, 32'h0,        32'h41,  4'hE, 32'h0000E400, 4};
        vt[5] = '{2, 32'h10,  2'd2, 1'b1, 32'hDEADBEEF, 32'h10,  4'h0, 32'h0,        6};

        na = '0; addr = '0; xsz = '0; nrd = 1'b0; wdata = '0;
        repeat (2) @(posedge hclk17);
        @(negedge hclk17);
        for (int q = 0; q < 3; q++) chk_reset(q);
        #2 n_sys_reset17 = 1'b1;

        // Directed vectors.
        for (int v = 0; v < 6; v++) begin
            @(posedge hclk17); #1;
            xfer(vt[v].inst, vt[v].a, vt[v].sz, vt[v].w, vt[v].wd, 1'b0, ea0, be0, rdf, cyc);
            chk("tbl_addr", vt[v].inst, v, ea0,        vt[v].ea0);
            chk("tbl_be",   vt[v].inst, v, 32'(be0),   32'(vt[v].be0));
            chk("tbl_rd",   vt[v].inst, v, rdf,        vt[v].rd);
            chk("tbl_cyc",  vt[v].inst, v, 32'(cyc),   32'(vt[v].cyc));
        end

        // Back-to-back: second request in the final done cycle, no idle gap.
        @(posedge hclk17); #1;
        xfer(0, 32'h300, 2'd2, 1'b0, 32'h0, 1'b0, ea0, be0, rdf, cyc);
        chk("b2b_cyc1", 0, 0, 32'(cyc), 32'd8);
        xfer(0, 32'h305, 2'd0, 1'b1, 32'h0000C300, 1'b1, ea0, be0, rdf, cyc);
        chk("b2b_addr", 0, 0, ea0, 32'h304);
        chk("b2b_be",   0, 0, 32'(be0), 32'hD);
        chk("b2b_cyc2", 0, 0, 32'(cyc), 32'd4);

        // Reset pulse in the second STROBE cycle of a word read.
        @(posedge hclk17); #1;
        addr = 32'h500; xsz = 2'd2; nrd = 1'b0; na[0] = 1'b1;
        @(posedge hclk17); #1; na[0] = 1'b0;
        @(posedge hclk17); #1;
        @(posedge hclk17); #1;
        chk("pre_rst_oe", 0, 3, 32'(oe_o[0]), 32'd0);
        #1 n_sys_reset17 = 1'b0;
        #1 chk_reset(0);
        #1 n_sys_reset17 = 1'b1;
        @(negedge hclk17);
        chk("post_rst_idle", 0, 0, 32'(idle_o[0]), 32'd1);
        @(posedge hclk17); #1;
        xfer(0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, ea0, be0, rdf, cyc);
        chk("post_rst_rd",  0, 0, rdf, 32'hBBBBAAAA);
        chk("post_rst_cyc", 0, 0, 32'(cyc), 32'd8);

        // Random transfers, sometimes chained back-to-back on the same instance.
        prev = -1;
        for (int it = 0; it < 40; it++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            chain = (prev >= 0) && ($urandom_range(0, 1) == 1);
            if (chain) begin
                i = prev;
            end else begin
                @(posedge hclk17); #1;
                i = int'($urandom_range(0, 2));
            end
            xfer(i, a, sz, w, wd, chain, ea0, be0, rdf, cyc);
            chk("rnd_end", i, it, 32'(cyc == 0), 32'd0);
            prev = i;
        end

        @(posedge hclk17); #1;
        @(negedge hclk17);
        for (int q = 0; q < 3; q++) chk("final_idle", q, 0, 32'(idle_o[q]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
